aes_round_engine: RTL and testbench

//   Iterative AES encryption core: one round datapath reused over NR+1 clock cycles to

---
 rtl/aes_round_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_aes_round_engine.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_engine.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_engine
// Description : Iterative AES encryption core. One combinational round
//               (SubBytes -> ShiftRows -> MixColumns -> AddRoundKey) is
//               reused over NR+1 cycles to encrypt a 128-bit block.
//               Round keys come from an external combinational store
//               addressed by key_idx_o. The core handles one block at a
//               time, with valid/ready handshakes on input and output.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_engine #(
    parameter int NR     = 10,
    parameter int KIDX_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [127:0]      in_data_i,
    output logic [KIDX_W-1:0] key_idx_o,
    input  logic [127:0]      round_key_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [127:0]      out_data_o,
    output logic              busy_o
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
            $fatal(1, "aes_round_engine: NR must be 10, 12 or 14");
        end
        if ((2 ** KIDX_W) <= NR) begin : g_bad_kidx_w
            $fatal(1, "aes_round_engine: KIDX_W too narrow to address round NR");
        end
    endgenerate

    // Index of the final round, i.e. the one that skips MixColumns.
    localparam logic [KIDX_W-1:0] c_LAST_RND = KIDX_W'(NR);

    // AES forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // ------------------------------------------------------------------------
    // Round building blocks. The state is column-major: byte i = row (i%4),
    // column (i/4), and byte 0 sits in bits [127:120].
    // ------------------------------------------------------------------------

    // Byte b lives at bits [8*(255-b)+7 -: 8]; {~b, 3'b111} is that top bit.
    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        return c_SBOX[{~b, 3'b111} -: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes: every byte goes through the S-box independently.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = sbox_lookup(s[8*i +: 8]);
        end
        return r;
    endfunction

    // ShiftRows: row rr rotates left by rr columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                r[127 - 8*(rr + 4*c) -: 8] = s[127 - 8*(rr + 4*((c + rr) % 4)) -: 8];
            end
        end
        return r;
    endfunction

    // MixColumns: each column multiplied by the circulant {02,03,01,01}.
    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            r[127 - 32*c -: 8] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
            r[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
            r[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
            r[103 - 32*c -: 8] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    // AddRoundKey: plain XOR with the round key.
    function automatic logic [127:0] add_round_key(input logic [127:0] s,
                                                   input logic [127:0] k);
        return s ^ k;
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [KIDX_W-1:0]   rnd_q,   rnd_d;
    logic [127:0]        st_q,    st_d;

    // ------------------------------------------------------------------------
    // Round datapath: one full round per cycle from the registered state.
    // The final round feeds ShiftRows straight into AddRoundKey.
    // ------------------------------------------------------------------------
    logic [127:0] w_sb;
    logic [127:0] w_sr;
    logic [127:0] w_mc;
    logic         w_last;
    logic [127:0] w_round_out;

    assign w_sb        = sub_bytes(st_q);
    assign w_sr        = shift_rows(w_sb);
    assign w_mc        = mix_columns(w_sr);
    assign w_last      = (rnd_q == c_LAST_RND);
    assign w_round_out = add_round_key(w_last ? w_sr : w_mc, round_key_i);

    // State, round counter and cipher-state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            rnd_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
        end
    end

    // Next-state logic and Moore outputs for IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        st_d        = st_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        key_idx_o   = '0;
        busy_o      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Key 0 is presented so the initial AddRoundKey happens
                // on the accepting edge itself.
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    st_d    = add_round_key(in_data_i, round_key_i);
                    rnd_d   = KIDX_W'(1);
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                busy_o    = 1'b1;
                key_idx_o = rnd_q;
                st_d      = w_round_out;
                if (w_last) begin
                    // Counter parks at zero so it never runs past NR.
                    rnd_d   = '0;
                    state_d = S_DONE;
                end else begin
                    rnd_d   = rnd_q + KIDX_W'(1);
                end
            end

            S_DONE: begin
                // Ciphertext is held here for as long as downstream stalls.
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                out_data_o  = st_q;
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                rnd_d   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_round_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_engine
// Description : Scoreboard bench for aes_round_engine. Two instances
//               (NR=10 and NR=14) each get a combinational round-key store
//               and a monitor that pops expected ciphertexts on every
//               output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_engine;

    localparam logic [127:0] c_B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_C_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] c_C3_KEY =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] c_C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A: NR = 10 ----------------
    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [127:0] a_in_data, a_out_data, a_round_key;
    logic [3:0]   a_key_idx;
    logic [127:0] a_rk [0:15];
    assign a_round_key = a_rk[a_key_idx];

    aes_round_engine #(.NR(10), .KIDX_W(4)) u_dut10 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (a_in_valid),
        .in_ready_o  (a_in_ready),
        .in_data_i   (a_in_data),
        .key_idx_o   (a_key_idx),
        .round_key_i (a_round_key),
        .out_valid_o (a_out_valid),
        .out_ready_i (a_out_ready),
        .out_data_o  (a_out_data),
        .busy_o      (a_busy)
    );

    // ---------------- instance B: NR = 14 ----------------
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [127:0] b_in_data, b_out_data, b_round_key;
    logic [3:0]   b_key_idx;
    logic [127:0] b_rk [0:15];
    assign b_round_key = b_rk[b_key_idx];

    aes_round_engine #(.NR(14), .KIDX_W(4)) u_dut14 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (b_in_valid),
        .in_ready_o  (b_in_ready),
        .in_data_i   (b_in_data),
        .key_idx_o   (b_key_idx),
        .round_key_i (b_round_key),
        .out_valid_o (b_out_valid),
        .out_ready_i (b_out_ready),
        .out_data_o  (b_out_data),
        .busy_o      (b_busy)
    );

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbx [0:255];

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box derived from the field inverse and affine map, not a table.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbx[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbx[t[31:24]], sbx[t[23:16]], sbx[t[15:8]], sbx[t[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk, input int nr, input bit to_b);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4 * (nr + 1); i++) begin
            if (i < nk) begin
                w[i] = key[255 - 32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xt(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        for (int r = 0; r <= nr; r++) begin
            if (to_b) b_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else      a_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    function automatic logic [127:0] ref_enc(input logic [127:0] pt);
        logic [7:0] b [0:15];
        logic [7:0] o [0:15];
        logic [127:0] s;
        s = pt ^ a_rk[0];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) b[i] = sbx[s[127 - 8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    o[rr + 4*c] = b[rr + 4*((c + rr) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    b[4*c]   = gmul(8'h02, o[4*c]) ^ gmul(8'h03, o[4*c+1]) ^ o[4*c+2] ^ o[4*c+3];
                    b[4*c+1] = o[4*c] ^ gmul(8'h02, o[4*c+1]) ^ gmul(8'h03, o[4*c+2]) ^ o[4*c+3];
                    b[4*c+2] = o[4*c] ^ o[4*c+1] ^ gmul(8'h02, o[4*c+2]) ^ gmul(8'h03, o[4*c+3]);
                    b[4*c+3] = gmul(8'h03, o[4*c]) ^ o[4*c+1] ^ o[4*c+2] ^ gmul(8'h02, o[4*c+3]);
                end
                for (int i = 0; i < 16; i++) o[i] = b[i];
            end
            for (int i = 0; i < 16; i++) s[127 - 8*i -: 8] = o[i];
            s = s ^ a_rk[r];
        end
        return s;
    endfunction

    // ---------------- scoreboards and monitors ----------------
    logic [127:0] qa[$];
    logic [127:0] qb[$];
    int a_pops = 0;

    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_output: got %h with no block outstanding", a_out_data);
            end else begin
                chk("a_out_data", a_out_data, qa.pop_front());
            end
            a_pops++;
        end
    end

    always @(negedge clk) begin
        if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_output: got %h with no block outstanding", b_out_data);
            end else begin
                chk("b_out_data", b_out_data, qb.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic issue_a(input logic [127:0] pt, input bit trace, output int acc);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        acc = -1;
        a_in_data  = pt;
        a_in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (a_in_ready) begin
                done = 1'b1;
                acc  = cyc;
                if (trace) chk("a_kidx_trace_0", 128'(a_key_idx), 128'(0));
            end else begin
                n++;
                if (n > 300) begin
                    done = 1'b1;
                    checks++;
                    errors++;
                    $display("FAIL a_accept_timeout: in_ready still %0b after %0d cycles, required 1", a_in_ready, n);
                end
            end
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        a_in_data  = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    endtask

    task automatic wait_valid_a(output int c);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        c = -1;
        while (!done) begin
            @(negedge clk);
            if (a_out_valid) begin
                done = 1'b1;
                c = cyc;
            end else begin
                n++;
                if (n > 100) begin
                    done = 1'b1;
                    checks++;
                    errors++;
                    $display("FAIL a_output_timeout: out_valid still %0b after %0d cycles, required 1", a_out_valid, n);
                end
            end
        end
    endtask

    task automatic issue_b(input logic [127:0] pt, output int acc);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        acc = -1;
        b_in_data  = pt;
        b_in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (b_in_ready) begin
                done = 1'b1;
                acc  = cyc;
            end else begin
                n++;
                if (n > 300) begin
                    done = 1'b1;
                    checks++;
                    errors++;
                    $display("FAIL b_accept_timeout: in_ready still %0b, required 1", b_in_ready);
                end
            end
        end
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic wait_valid_b(output int c);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        c = -1;
        while (!done) begin
            @(negedge clk);
            if (b_out_valid) begin
                done = 1'b1;
                c = cyc;
            end else begin
                n++;
                if (n > 100) begin
                    done = 1'b1;
                    checks++;
                    errors++;
                    $display("FAIL b_output_timeout: out_valid still %0b, required 1", b_out_valid);
                end
            end
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int t, c, target;

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;

        build_sbox();
        expand({c_C1_KEY, 128'h0}, 4, 10, 1'b0);
        chk("model_c1_selfcheck", ref_enc(c_C_PT), c_C1_CT);
        expand({c_B_KEY, 128'h0}, 4, 10, 1'b0);
        expand(c_C3_KEY, 8, 14, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 128'(a_out_valid), 128'(0));
        chk("rst_out_data",  a_out_data,        128'h0);
        chk("rst_busy",      128'(a_busy),      128'(0));
        chk("rst_in_ready",  128'(a_in_ready),  128'(1));
        chk("rst_key_idx",   128'(a_key_idx),   128'(0));
        chk("rst_b_in_ready", 128'(b_in_ready), 128'(1));
        @(posedge clk);
        #1;

        // FIPS-197 appendix B, latency T+11
        qa.push_back(c_B_CT);
        issue_a(c_B_PT, 1'b0, t);
        wait_valid_a(c);
        chk("b_vec_latency", 128'(c - t), 128'(11));
        chk("b_vec_done_in_ready", 128'(a_in_ready), 128'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("b_vec_idle_in_ready", 128'(a_in_ready), 128'(1));
        chk("b_vec_idle_busy", 128'(a_busy), 128'(0));
        @(posedge clk);
        #1;

        // FIPS-197 C.1 with key_idx trace 0..10
        expand({c_C1_KEY, 128'h0}, 4, 10, 1'b0);
        qa.push_back(c_C1_CT);
        issue_a(c_C_PT, 1'b1, t);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("c1_kidx_trace_%0d", k), 128'(a_key_idx), 128'(k));
        end
        wait_valid_a(c);
        chk("c1_latency", 128'(c - t), 128'(11));
        chk("c1_done_key_idx", 128'(a_key_idx), 128'(0));
        @(posedge clk);
        #1;

        // FIPS-197 C.3 on the NR=14 instance, latency T+15
        qb.push_back(c_C3_CT);
        issue_b(c_C_PT, t);
        wait_valid_b(c);
        chk("c3_latency", 128'(c - t), 128'(15));
        @(posedge clk);
        #1;

        // Backpressure: 20 stalled cycles with a competing in_valid
        a_out_ready = 1'b0;
        qa.push_back(c_C1_CT);
        issue_a(c_C_PT, 1'b0, t);
        wait_valid_a(c);
        @(posedge clk);
        #1;
        a_in_valid = 1'b1;
        a_in_data  = 128'h0f0e0d0c0b0a09080706050403020100;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 128'(a_out_valid), 128'(1));
            chk("bp_out_data",  a_out_data,        c_C1_CT);
            chk("bp_in_ready",  128'(a_in_ready),  128'(0));
        end
        @(posedge clk);
        #1;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_release_in_ready",  128'(a_in_ready),  128'(1));
        chk("bp_release_out_valid", 128'(a_out_valid), 128'(0));
        chk("bp_release_busy",      128'(a_busy),      128'(0));
        @(posedge clk);
        #1;

        // Reset asserted at rnd=5; the block must vanish
        issue_a(c_C_PT, 1'b0, t);
        repeat (5) @(negedge clk);
        chk("rst_mid_key_idx_5", 128'(a_key_idx), 128'(5));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_out_valid", 128'(a_out_valid), 128'(0));
        chk("rst_mid_busy",      128'(a_busy),      128'(0));
        chk("rst_mid_in_ready",  128'(a_in_ready),  128'(1));
        @(posedge clk);
        #1;
        qa.push_back(c_C1_CT);
        issue_a(c_C_PT, 1'b0, t);
        wait_valid_a(c);
        chk("after_rst_latency", 128'(c - t), 128'(11));
        @(posedge clk);
        #1;

        // Streaming: 8 random blocks, random input gaps and output stalls
        target = a_pops + 8;
        fork
            begin
                for (int n = 0; n < 8; n++) begin
                    logic [127:0] pt;
                    pt = {$urandom, $urandom, $urandom, $urandom};
                    qa.push_back(ref_enc(pt));
                    repeat ($urandom_range(0, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                    issue_a(pt, 1'b0, t);
                end
            end
            begin
                int lim;
                lim = 0;
                while (a_pops < target && lim < 3000) begin
                    @(posedge clk);
                    #1;
                    a_out_ready = 1'($urandom_range(0, 1));
                    lim++;
                end
                a_out_ready = 1'b1;
            end
        join
        chk("stream_pop_count", 128'(a_pops), 128'(target));

        repeat (3) @(posedge clk);
        chk("final_qa_empty", 128'(qa.size()), 128'(0));
        chk("final_qb_empty", 128'(qb.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
